// File: rtl/id_stage_piped_if.sv
// id_stage_piped_if: IF/ID/EX handshake, write-back and ID/EX register bundle for id_stage_piped.
interface id_stage_piped_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [XLEN-1:0]   in_pc;
    logic              ex_ready;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              mem_to_reg;
    logic              alu_src;
    logic              illegal;

    modport master (
        output in_valid, instruction, in_pc, ex_ready, flush, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_pc, rs1_data, rs2_data, imm, rd, alu_sel,
               reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, illegal
    );

    modport slave (
        input  in_valid, instruction, in_pc, ex_ready, flush, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_pc, rs1_data, rs2_data, imm, rd, alu_sel,
               reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, illegal
    );
endinterface

// File: rtl/id_stage_piped.sv
// id_stage_piped: RV32I decode with register file, load-use stall and ID/EX register.
// Define ID_WB_BYPASS_EN to make the read ports write-through for a same-cycle write-back.
module id_stage_piped #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic          clk,
    input logic          reset,
    id_stage_piped_if.slave bus
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [XLEN-1:0]   rf_q [2**REG_AW];
    logic [31:0]       ins;
    logic [REG_AW-1:0] rs1_a, rs2_a, rd_a;
    logic              is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal;
    logic              use_rs1, use_rs2, hazard, advance;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_d, rs1_d, rs2_d;
    logic [3:0]        alu_d;
    // {illegal, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src}
    logic [6:0]        ctrl_d, ctrl_q;
    logic              valid_q;
    logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [3:0]        alu_q;

    assign ins    = bus.instruction;
    assign rs1_a  = REG_AW'(ins[19:15]);
    assign rs2_a  = REG_AW'(ins[24:20]);
    assign rd_a   = REG_AW'(ins[11:7]);
    assign is_r   = ins[6:0] == OP_R;
    assign is_i   = ins[6:0] == OP_I;
    assign is_ld  = ins[6:0] == OP_LD;
    assign is_st  = ins[6:0] == OP_ST;
    assign is_br  = ins[6:0] == OP_BR;
    assign is_lui = ins[6:0] == OP_LUI;
    assign is_jal = ins[6:0] == OP_JAL;

    assign imm32 = (is_i || is_ld) ? {{20{ins[31]}}, ins[31:20]} :
                   is_st  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                   is_br  ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
                   is_lui ? {ins[31:12], 12'b0} :
                   is_jal ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} : '0;
    assign imm_d = XLEN'($signed(imm32));

    always_comb begin
        alu_d = 4'd0;
        if (is_r || is_i)
            case (ins[14:12])
                3'd0:    alu_d = (is_r && ins[30]) ? 4'd1 : 4'd0;
                3'd1:    alu_d = 4'd5;
                3'd2:    alu_d = 4'd8;
                3'd3:    alu_d = 4'd9;
                3'd4:    alu_d = 4'd4;
                3'd5:    alu_d = ins[30] ? 4'd7 : 4'd6;
                3'd6:    alu_d = 4'd3;
                default: alu_d = 4'd2;
            endcase
        else if (is_br)
            alu_d = 4'd1;
    end

    assign ctrl_d = {!(is_r || is_i || is_ld || is_st || is_br || is_lui || is_jal),
                     (is_r || is_i || is_ld || is_lui || is_jal) && rd_a != '0,
                     is_ld, is_st, is_br, is_ld,
                     is_i || is_ld || is_st || is_lui || is_jal};

`ifdef ID_WB_BYPASS_EN
    assign rs1_d = (rs1_a == '0) ? '0 : (bus.wb_en && bus.wb_rd == rs1_a) ? bus.wb_data : rf_q[rs1_a];
    assign rs2_d = (rs2_a == '0) ? '0 : (bus.wb_en && bus.wb_rd == rs2_a) ? bus.wb_data : rf_q[rs2_a];
`else
    assign rs1_d = (rs1_a == '0) ? '0 : rf_q[rs1_a];
    assign rs2_d = (rs2_a == '0) ? '0 : rf_q[rs2_a];
`endif

    assign use_rs1 = !(is_lui || is_jal);
    assign use_rs2 = is_r || is_st || is_br;
    assign hazard  = valid_q && ctrl_q[4] && rd_q != '0 &&
                     ((use_rs1 && rs1_a == rd_q) || (use_rs2 && rs2_a == rd_q));
    assign advance = !valid_q || bus.ex_ready;
    assign bus.in_ready = advance && !hazard;

    always_ff @(posedge clk)
        if (!reset)
            rf_q <= '{default: '0};
        else if (bus.wb_en && bus.wb_rd != '0)
            rf_q[bus.wb_rd] <= bus.wb_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (advance && hazard) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (advance && bus.in_valid) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            pc_q    <= bus.in_pc;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_a;
            alu_q   <= alu_d;
        end else if (advance) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_pc     = pc_q;
    assign bus.rs1_data   = rs1_q;
    assign bus.rs2_data   = rs2_q;
    assign bus.imm        = imm_q;
    assign bus.rd         = rd_q;
    assign bus.alu_sel    = alu_q;
    assign bus.illegal    = ctrl_q[6];
    assign bus.reg_write  = ctrl_q[5];
    assign bus.mem_read   = ctrl_q[4];
    assign bus.mem_write  = ctrl_q[3];
    assign bus.branch     = ctrl_q[2];
    assign bus.mem_to_reg = ctrl_q[1];
    assign bus.alu_src    = ctrl_q[0];
endmodule
